// File: rtl/pmcc_loader_pkg.sv
// pmcc_loader_pkg: shared state encoding and load-length limit for the code loader
package pmcc_loader_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;
   localparam int MAX_WORDS_DEFAULT = 1024;
endpackage

// File: rtl/ibex_data_bus.sv
// ibex_data_bus: request/grant/response data bus between an initiator and a memory
interface ibex_data_bus;
   logic req, gnt, rvalid, err, we;
   logic [3:0] be;
   logic [31:0] addr, wdata, rdata;
   modport master (output req, addr, we, be, wdata, input gnt, rvalid, err, rdata);
   modport slave (input req, addr, we, be, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/pmcc_code_loader.sv
// pmcc_code_loader: streams words to memory over the data bus, then optionally reads back and checksums them
module pmcc_code_loader
   import pmcc_loader_pkg::*;
#(
   parameter bit VERIFY = 1'b1,
   parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [10:0] word_cnt,
   input  logic [31:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   ibex_data_bus.master data_bus
);
   state_t state, state_nx;
   logic [31:0] base, wdata, wsum, rsum;
   logic [10:0] cnt, idx;
   logic [3:0] be;
   logic req, we, last, bad_cnt, req_nx;
   assign last = idx + 11'd1 >= cnt;
   assign bad_cnt = 32'(word_cnt) > MAX_WORDS;
   assign req_nx = state_nx == WR_REQ || state_nx == RD_REQ;
   assign data_bus.req = req;
   assign data_bus.we = we;
   assign data_bus.be = be;
   assign data_bus.wdata = wdata;
   assign data_bus.addr = base + {19'b0, idx, 2'b00};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start) state_nx = (word_cnt == 11'd0 || bad_cnt) ? FINISH : WAIT_DATA;
         WAIT_DATA: if (din_valid) state_nx = WR_REQ;
         WR_REQ:    if (data_bus.gnt) state_nx = WR_RESP;
         WR_RESP:   if (data_bus.rvalid) state_nx = data_bus.err ? FINISH : !last ? WAIT_DATA : VERIFY ? RD_REQ : FINISH;
         RD_REQ:    if (data_bus.gnt) state_nx = RD_RESP;
         RD_RESP:   if (data_bus.rvalid) state_nx = (data_bus.err || last) ? FINISH : RD_REQ;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         req <= 1'b0;
         we <= 1'b0;
         be <= 4'h0;
         base <= '0;
         cnt <= '0;
         idx <= '0;
         wdata <= '0;
         wsum <= '0;
         rsum <= '0;
         din_ready <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_nx;
         busy <= state_nx != IDLE;
         din_ready <= state_nx == WAIT_DATA;
         done <= state_nx == FINISH;
         req <= req_nx;
         we <= state_nx == WR_REQ;
         be <= req_nx ? 4'hF : 4'h0;
         case (state)
            IDLE: if (start) begin
               base <= base_addr & 32'hFFFF_FFFC;
               cnt <= word_cnt;
               idx <= '0;
               wsum <= '0;
               rsum <= '0;
               error <= bad_cnt;
            end
            WAIT_DATA: if (din_valid) wdata <= din;
            WR_RESP: if (data_bus.rvalid) begin
               if (data_bus.err) error <= 1'b1;
               else begin
                  wsum <= wsum + wdata;
                  idx <= last ? '0 : idx + 11'd1;
               end
            end
            RD_RESP: if (data_bus.rvalid) begin
               if (data_bus.err) error <= 1'b1;
               else begin
                  rsum <= rsum + data_bus.rdata;
                  idx <= idx + 11'd1;
                  if (last) error <= rsum + data_bus.rdata != wsum;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pmcc_code_loader.sv
// tb_pmcc_code_loader: randomized bench with a memory responder and a load-level reference model
module tb_pmcc_code_loader;
   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, din_valid = 1'b0;
   logic [31:0] base_addr = '0, din = '0;
   logic [10:0] word_cnt = '0;
   logic din_ready, busy, done, error;
   int errors = 0, checks = 0;
   int gnt_dly = 0, rsp_dly = 0, err_wr = -1, bad_rd = -1;
   logic [31:0] bad_mask = '0;
   int req_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, stab_err = 0, be_err = 0;
   logic [31:0] words[$], wr_addr[$], wr_data[$], rd_addr[$];
   logic [31:0] mem[logic [31:0]];
   logic [31:0] snap[logic [31:0]];
   bit pend = 0, in_req = 0;
   int wcnt = 0, rwait = 0;
   logic pend_err = 1'b0, cap_we = 1'b0;
   logic [31:0] pend_rdata = '0, cap_a = '0, cap_d = '0;

   ibex_data_bus bus ();

   pmcc_code_loader #(.VERIFY(1'b1), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
      .din(din), .din_valid(din_valid), .din_ready(din_ready), .busy(busy), .done(done),
      .error(error), .data_bus(bus)
   );

   always #5 clk = ~clk;

   // memory responder: acts on the falling edge so the DUT sees stable gnt/rvalid at the rising edge
   initial begin
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0; bus.rdata = '0;
      forever begin
         @(negedge clk);
         bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0;
         if (done) done_cnt++;
         if (rst) in_req = 0;
         if (pend) begin
            if (rwait == 0) begin
               bus.rvalid = 1'b1; bus.err = pend_err; bus.rdata = pend_rdata; pend = 0;
            end else rwait--;
         end else if (bus.req === 1'b1 && !rst) begin
            if (!in_req) begin
               in_req = 1; cap_a = bus.addr; cap_d = bus.wdata; cap_we = bus.we; wcnt = 0;
            end else if (bus.addr !== cap_a || bus.wdata !== cap_d || bus.we !== cap_we) stab_err++;
            if (bus.be !== 4'hF) be_err++;
            if (wcnt >= gnt_dly) begin
               bus.gnt = 1'b1; in_req = 0; req_cnt++; pend = 1; rwait = rsp_dly;
               if (bus.we) begin
                  pend_err = wr_cnt == err_wr;
                  wr_addr.push_back(bus.addr); wr_data.push_back(bus.wdata);
                  if (!pend_err) mem[bus.addr] = bus.wdata;
                  wr_cnt++;
               end else begin
                  pend_err = 1'b0;
                  pend_rdata = mem.exists(bus.addr) ? mem[bus.addr] : 32'h0;
                  if (rd_cnt == bad_rd) pend_rdata = pend_rdata ^ bad_mask;
                  rd_addr.push_back(bus.addr); rd_cnt++;
               end
            end else wcnt++;
         end
      end
   end

   task automatic clear_bus();
      @(posedge clk);
      wr_addr.delete(); wr_data.delete(); rd_addr.delete(); mem.delete();
      req_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; stab_err = 0; be_err = 0;
      gnt_dly = 0; rsp_dly = 0; err_wr = -1; bad_rd = -1; bad_mask = '0;
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   // load-level expectations: requests issued, reads issued, final error
   function automatic void model(input int n, output int nw, output int nr, output logic e);
      nw = 0; nr = 0; e = n > 1024;
      if (n > 0 && n <= 1024) begin
         if (err_wr >= 0 && err_wr < n) begin
            nw = err_wr + 1; e = 1'b1;
         end else begin
            nw = n; nr = n; e = bad_rd >= 0 && bad_rd < n;
         end
      end
   endfunction

   function automatic int log_bad(input logic [31:0] b, input int nw, input int nr);
      int bad = (wr_addr.size() != nw || rd_addr.size() != nr) ? 1 : 0;
      logic [31:0] a0 = b & 32'hFFFF_FFFC;
      for (int i = 0; i < wr_addr.size() && i < words.size(); i++)
         if (wr_addr[i] !== a0 + 32'(4 * i) || wr_data[i] !== words[i]) bad++;
      for (int i = 0; i < rd_addr.size(); i++)
         if (rd_addr[i] !== a0 + 32'(4 * i)) bad++;
      return bad;
   endfunction

   task automatic run_load(input logic [31:0] b, input int n, input bit gaps, output bit got, output int lat);
      int ptr = 0;
      bit acc;
      got = 0; lat = -1;
      @(negedge clk); base_addr = b; word_cnt = 11'(n); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int t = 0; t < 2000 && !got; t++) begin
         din_valid = ptr < words.size() && (!gaps || $urandom_range(0, 2) == 0);
         din = din_valid ? words[ptr] : $urandom;
         acc = din_valid && din_ready;
         if (done) begin got = 1; lat = t; end
         @(negedge clk);
         if (acc) ptr++;
      end
      din_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({busy, done, error, din_ready, bus.req, bus.we, bus.be, bus.addr, bus.wdata} !== '0) begin errors++; $display("FAIL reset_outputs: got busy=%b done=%b error=%b rdy=%b req=%b we=%b be=%h addr=%h wdata=%h want all zero", busy, done, error, din_ready, bus.req, bus.we, bus.be, bus.addr, bus.wdata); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({busy, bus.req} !== 2'b00) begin errors++; $display("FAIL reset_idle: got busy=%b req=%b want 0 0", busy, bus.req); end
   endtask

   task automatic test_basic();
      bit got; int lat, nw, nr, bad; logic e;
      clear_bus();
      words = '{32'd1, 32'd2, 32'd3, 32'd4};
      model(4, nw, nr, e);
      run_load(32'h0, 4, 0, got, lat);
      bad = log_bad(32'h0, nw, nr);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_done: got=%0b want=1", got); end
      checks++; if (error !== e) begin errors++; $display("FAIL basic_error: got=%b want=%b", error, e); end
      checks++; if (lat !== 20) begin errors++; $display("FAIL basic_latency: got=%0d want=20", lat); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_log: got %0d bad entries want 0", bad); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got=%0d want=1", done_cnt); end
      checks++; if (be_err !== 0) begin errors++; $display("FAIL basic_be: got %0d bad be want 0", be_err); end
   endtask

   task automatic test_stall();
      bit got; int lat, bad, diff;
      logic [31:0] b = $urandom & 32'h0000_FFFC;
      clear_bus();
      fill_words(6);
      run_load(b, 6, 0, got, lat);
      snap = mem;
      clear_bus();
      gnt_dly = 3; rsp_dly = 2;
      run_load(b, 6, 1, got, lat);
      bad = log_bad(b, 6, 6);
      diff = (snap.size() != mem.size() || snap.size() != 6) ? 1 : 0;
      foreach (snap[k]) if (!mem.exists(k) || mem[k] !== snap[k]) diff++;
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL stall_done: got=%0b want=1", got); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL stall_error: got=%b want=0", error); end
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes while req want 0", stab_err); end
      checks++; if (diff !== 0) begin errors++; $display("FAIL stall_memory: got %0d differing words want 0", diff); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall_log: got %0d bad entries want 0", bad); end
   endtask

   task automatic test_write_err();
      bit got; int lat;
      clear_bus();
      fill_words(4);
      err_wr = 1;
      run_load(32'h100, 4, 0, got, lat);
      repeat (8) @(negedge clk);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL werr_done: got=%0b want=1", got); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL werr_error: got=%b want=1", error); end
      checks++; if (req_cnt !== 2) begin errors++; $display("FAIL werr_requests: got=%0d want=2", req_cnt); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL werr_done_pulses: got=%0d want=1", done_cnt); end
   endtask

   task automatic test_read_corrupt();
      bit got; int lat;
      clear_bus();
      words = '{32'd1, 32'd2, 32'd3, 32'd4};
      bad_rd = 2; bad_mask = 32'h4;
      run_load(32'h0, 4, 0, got, lat);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rcor_done: got=%0b want=1", got); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL rcor_error: got=%b want=1", error); end
      checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL rcor_reads: got=%0d want=4", rd_cnt); end
   endtask

   task automatic test_bad_count();
      bit got; int lat;
      clear_bus();
      words.delete();
      run_load(32'h40, 0, 0, got, lat);
      checks++; if (got !== 1'b1 || lat !== 0) begin errors++; $display("FAIL cnt0_done: got done=%0b lat=%0d want 1 0", got, lat); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL cnt0_error: got=%b want=0", error); end
      run_load(32'h40, 1025, 0, got, lat);
      checks++; if (got !== 1'b1 || lat !== 0) begin errors++; $display("FAIL cnt1025_done: got done=%0b lat=%0d want 1 0", got, lat); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL cnt1025_error: got=%b want=1", error); end
      run_load(32'h40, 0, 0, got, lat);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_cleared: got=%b want=0", error); end
      checks++; if (req_cnt !== 0) begin errors++; $display("FAIL badcnt_requests: got=%0d want=0", req_cnt); end
   endtask

   task automatic test_start_ignored();
      bit got; int lat, bad;
      logic [31:0] b = 32'h0000_2000;
      clear_bus();
      fill_words(4);
      gnt_dly = 1;
      fork
         run_load(b, 4, 0, got, lat);
         begin
            repeat (6) @(negedge clk);
            base_addr = 32'h1234_0000; word_cnt = 11'd2; start = 1'b1;
            @(negedge clk); start = 1'b0;
         end
      join
      bad = log_bad(b, 4, 4);
      checks++; if (bad !== 0 || error !== 1'b0) begin errors++; $display("FAIL busy_start: got %0d bad entries error=%b want 0 0", bad, error); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_pulses: got=%0d want=1", done_cnt); end
   endtask

   task automatic test_reset_midway();
      bit got; int lat, bad;
      clear_bus();
      fill_words(4);
      rsp_dly = 6; err_wr = 0;
      @(negedge clk); base_addr = 32'h80; word_cnt = 11'd4; start = 1'b1;
      @(negedge clk); start = 1'b0; din_valid = 1'b1; din = words[0];
      for (int t = 0; t < 200 && wr_cnt < 1; t++) @(negedge clk);
      din_valid = 1'b0;
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL rstmid_grant: got %0d writes want 1", wr_cnt); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++; if ({busy, done, error, din_ready, bus.req, bus.we, bus.be, bus.addr, bus.wdata} !== '0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b req=%b we=%b be=%h addr=%h wdata=%h want all zero", busy, bus.req, bus.we, bus.be, bus.addr, bus.wdata); end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if ({busy, error} !== 2'b00) begin errors++; $display("FAIL rstmid_stale: got busy=%b error=%b want 0 0", busy, error); end
      clear_bus();
      run_load(32'h80, 4, 0, got, lat);
      bad = log_bad(32'h80, 4, 4);
      checks++; if (got !== 1'b1 || error !== 1'b0 || bad !== 0) begin errors++; $display("FAIL rstmid_reload: got done=%0b error=%b bad=%0d want 1 0 0", got, error, bad); end
   endtask

   task automatic test_random();
      bit got; int lat, n, nw, nr, bad; logic e; logic [31:0] b;
      for (int k = 0; k < 8; k++) begin
         clear_bus();
         n = (k == 0) ? 8 : int'($urandom_range(1, 8));
         b = (k == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 3)) : $urandom;
         fill_words(n);
         gnt_dly = $urandom_range(0, 2); rsp_dly = $urandom_range(0, 2);
         err_wr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         bad_rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         bad_mask = $urandom | 32'h1;
         model(n, nw, nr, e);
         run_load(b, n, $urandom_range(0, 1) == 1, got, lat);
         repeat (3) @(negedge clk);
         bad = log_bad(b, nw, nr);
         checks++; if (got !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done: got done=%0b pulses=%0d want 1 1", k, got, done_cnt); end
         checks++; if (error !== e) begin errors++; $display("FAIL rand%0d_error: got=%b want=%b", k, error, e); end
         checks++; if (bad !== 0 || req_cnt !== nw + nr) begin errors++; $display("FAIL rand%0d_log: got bad=%0d reqs=%0d want 0 %0d", k, bad, req_cnt, nw + nr); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_write_err();
      test_read_corrupt();
      test_bad_count();
      test_start_ignored();
      test_reset_midway();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
